mcycle_unit: RTL and testbench

//  Multi-cycle multiply/divide responder for the ARM core datapath. The core's

---
 rtl/mcycle_unit.sv | 155 +++++++++++++++
 tb/tb_mcycle_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit: shift-add multiplier and restoring divider sharing one adder.
// Optional MCYCLE_EARLY_TERM_EN ends a MUL as soon as the remaining multiplier bits are zero.
module mcycle_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic [1:0]       MCycleOp,
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   output logic [WIDTH-1:0] Result1,
   output logic [WIDTH-1:0] Result2,
   output logic             Busy,
   output logic             Done
);
   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;
   state_e r_state, w_state_next;

   logic [WIDTH-1:0] r_hi, r_lo, r_opb, r_res1, r_res2;
   logic [CntW-1:0]  r_cnt;
   logic             r_is_div, r_div0, r_neg_lo, r_neg_hi;

   logic             w_signed, w_s1, w_s2;
   logic [WIDTH-1:0] w_mag1, w_mag2;

   assign w_signed = ~MCycleOp[0];
   assign w_s1     = w_signed & Operand1[WIDTH-1];
   assign w_s2     = w_signed & Operand2[WIDTH-1];
   assign w_mag1   = w_s1 ? -Operand1 : Operand1;
   assign w_mag2   = w_s2 ? -Operand2 : Operand2;

   // Shared adder: MUL adds the multiplicand into hi, DIV trial-subtracts the divisor.
   logic [WIDTH:0]   w_add_a, w_add_b, w_tmp;
   logic             w_cin, w_q_bit;
   logic [WIDTH+1:0] w_sum;
   logic [WIDTH-1:0] w_hi_n, w_lo_n;

   assign w_tmp = {r_hi, r_lo[WIDTH-1]};

   always_comb begin
      w_add_a = {1'b0, r_hi};
      w_add_b = '0;
      w_cin   = 1'b0;
      if (r_is_div) begin
         w_add_a = w_tmp;
         w_add_b = ~{1'b0, r_opb};
         w_cin   = 1'b1;
      end else if (r_lo[0]) begin
         w_add_b = {1'b0, r_opb};
      end
   end

   assign w_sum   = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(WIDTH+1){1'b0}}, w_cin};
   assign w_q_bit = w_sum[WIDTH+1];

   always_comb begin
      w_hi_n = w_sum[WIDTH:1];
      w_lo_n = {w_sum[0], r_lo[WIDTH-1:1]};
      if (r_is_div) begin
         w_hi_n = w_q_bit ? w_sum[WIDTH-1:0] : w_tmp[WIDTH-1:0];
         w_lo_n = {r_lo[WIDTH-2:0], w_q_bit};
      end
   end

   logic [2*WIDTH-1:0] w_prod_mag, w_prod;
   logic [WIDTH-1:0]   w_q_mag, w_r_mag, w_fin1, w_fin2;
   logic               w_last, w_early, w_finish;

   assign w_last = (r_cnt == CntW'(WIDTH-1));

`ifdef MCYCLE_EARLY_TERM_EN
   logic [CntW:0]    w_rest_sh, w_align_sh;
   logic [WIDTH-1:0] w_rest_mask;

   // After iteration k the unconsumed multiplier bits sit in w_lo_n[WIDTH-2-k:0].
   assign w_rest_sh   = {1'b0, r_cnt} + (CntW+1)'(1);
   assign w_rest_mask = {WIDTH{1'b1}} >> w_rest_sh;
   assign w_early     = ~r_is_div & ~|((r_lo >> 1) & w_rest_mask);
   assign w_align_sh  = (CntW+1)'(WIDTH-1) - {1'b0, r_cnt};
   assign w_prod_mag  = {w_hi_n, w_lo_n} >> w_align_sh;
`else
   assign w_early    = 1'b0;
   assign w_prod_mag = {w_hi_n, w_lo_n};
`endif

   assign w_prod   = r_neg_lo ? -w_prod_mag : w_prod_mag;
   assign w_q_mag  = r_div0 ? '1 : w_lo_n;
   assign w_r_mag  = r_div0 ? r_lo : w_hi_n;
   assign w_finish = r_div0 | w_last | w_early;

   always_comb begin
      w_fin1 = w_prod[WIDTH-1:0];
      w_fin2 = w_prod[2*WIDTH-1:WIDTH];
      if (r_is_div) begin
         w_fin1 = r_neg_lo ? -w_q_mag : w_q_mag;
         w_fin2 = r_neg_hi ? -w_r_mag : w_r_mag;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (Start) w_state_next = StCalc;
         StCalc:  if (w_finish) w_state_next = StDone;
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state  <= StIdle;
         r_hi     <= '0;
         r_lo     <= '0;
         r_opb    <= '0;
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_div0   <= 1'b0;
         r_neg_lo <= 1'b0;
         r_neg_hi <= 1'b0;
         r_res1   <= '0;
         r_res2   <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == StIdle && Start) begin
            r_is_div <= MCycleOp[1];
            r_div0   <= MCycleOp[1] & (Operand2 == '0);
            r_hi     <= '0;
            r_cnt    <= '0;
            r_lo     <= MCycleOp[1] ? w_mag1 : w_mag2;
            r_opb    <= MCycleOp[1] ? w_mag2 : w_mag1;
            // Divide by zero keeps the all-ones quotient unsigned; remainder sign restores Operand1.
            r_neg_lo <= (MCycleOp[1] & (Operand2 == '0)) ? 1'b0 : (w_s1 ^ w_s2);
            r_neg_hi <= MCycleOp[1] ? w_s1 : (w_s1 ^ w_s2);
         end else if (r_state == StCalc) begin
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
            r_cnt <= r_cnt + CntW'(1);
            if (w_finish) begin
               r_res1 <= w_fin1;
               r_res2 <= w_fin2;
            end
         end
      end
   end

   assign Result1 = r_res1;
   assign Result2 = r_res2;
   assign Busy    = (r_state != StIdle);
   assign Done    = (r_state == StDone);

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed, table-driven bench for mcycle_unit plus re-start and mid-operation reset sequences.
module tb_mcycle_unit;
   logic        CLK = 1'b0;
   logic        Reset_n = 1'b0;
   logic        Start = 1'b0;
   logic [1:0]  MCycleOp = 2'b00;
   logic [31:0] Operand1 = '0;
   logic [31:0] Operand2 = '0;
   logic [31:0] Result1, Result2;
   logic        Busy, Done;

   int n_checks = 0;
   int n_fail   = 0;

   mcycle_unit #(.WIDTH(32)) dut (
      .CLK      (CLK),
      .Reset_n  (Reset_n),
      .Start    (Start),
      .MCycleOp (MCycleOp),
      .Operand1 (Operand1),
      .Operand2 (Operand2),
      .Result1  (Result1),
      .Result2  (Result2),
      .Busy     (Busy),
      .Done     (Done)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r1;
      logic [31:0] r2;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Done-cycle offset from the Start cycle; MUL latency depends on the build.
   function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef MCYCLE_EARLY_TERM_EN
      logic [31:0] m;
      int k;
      if (op[1]) return (b == 0) ? 2 : 33;
      m = (!op[0] && b[31]) ? -b : b;
      k = 0;
      for (int i = 1; i < 32; i++) if (m[i]) k = i;
      return k + 2;
`else
      if (op[1]) return (b == 0) ? 2 : 33;
      return 33;
`endif
   endfunction

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
      @(negedge CLK);
      Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
      @(negedge CLK);
      Start = 1'b0;
      lat = 1;
      while (!Done && lat < 100) begin
         @(negedge CLK);
         lat++;
      end
   endtask

   initial begin
      int lat;
      int n_done;

      vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE};
      vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF};
      vecs[2]  = '{2'b00, 32'h00000007, 32'h00000005, 32'h00000023, 32'h00000000};
      vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF};
      vecs[4]  = '{2'b11, 32'd100,      32'd7,        32'd14,       32'd2};
      vecs[5]  = '{2'b11, 32'd1234,     32'd0,        32'hFFFFFFFF, 32'd1234};
      vecs[6]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
      vecs[7]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000};
      vecs[8]  = '{2'b01, 32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001};
      vecs[9]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001};
      vecs[10] = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFB};
      vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
      vecs[12] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
      vecs[13] = '{2'b11, 32'd5,        32'd10,       32'd0,        32'd5};

      repeat (2) @(negedge CLK);
      chk("reset_busy", {63'd0, Busy}, 64'd0);
      chk("reset_done", {63'd0, Done}, 64'd0);
      chk("reset_r1", {32'd0, Result1}, 64'd0);
      chk("reset_r2", {32'd0, Result2}, 64'd0);
      Reset_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].op, vecs[i].b)));
         chk($sformatf("vec%0d_r1", i), {32'd0, Result1}, {32'd0, vecs[i].r1});
         chk($sformatf("vec%0d_r2", i), {32'd0, Result2}, {32'd0, vecs[i].r2});
         @(negedge CLK);
         chk($sformatf("vec%0d_idle", i), {62'd0, Busy, Done}, 64'd0);
      end

      // Start re-pulsed mid-operation and again in the Done cycle.
      @(negedge CLK);
      Start = 1'b1; MCycleOp = 2'b11; Operand1 = 32'd100; Operand2 = 32'd7;
      @(negedge CLK);
      Start = 1'b0;
      chk("repulse_busy", {63'd0, Busy}, 64'd1);
      lat = 1;
      while (!Done && lat < 100) begin
         if (lat == 5) begin
            Start = 1'b1; MCycleOp = 2'b01; Operand1 = 32'd9; Operand2 = 32'd3;
         end else begin
            Start = 1'b0;
         end
         @(negedge CLK);
         lat++;
      end
      chk("repulse_latency", 64'(lat), 64'd33);
      chk("repulse_r1", {32'd0, Result1}, 64'd14);
      chk("repulse_r2", {32'd0, Result2}, 64'd2);
      Start = 1'b1; MCycleOp = 2'b01; Operand1 = 32'd9; Operand2 = 32'd3;
      @(negedge CLK);
      Start = 1'b0;
      n_done = 0;
      for (int c = 0; c < 40; c++) begin
         if (Done || Busy) n_done++;
         @(negedge CLK);
      end
      chk("repulse_no_second_op", 64'(n_done), 64'd0);
      chk("repulse_hold_r1", {32'd0, Result1}, 64'd14);

      // Reset in the middle of a divide.
      Start = 1'b1; MCycleOp = 2'b11; Operand1 = 32'd100; Operand2 = 32'd7;
      @(negedge CLK);
      Start = 1'b0;
      repeat (9) @(negedge CLK);
      Reset_n = 1'b0;
      #1;
      chk("midreset_busy", {63'd0, Busy}, 64'd0);
      chk("midreset_done", {63'd0, Done}, 64'd0);
      chk("midreset_r1", {32'd0, Result1}, 64'd0);
      chk("midreset_r2", {32'd0, Result2}, 64'd0);
      @(negedge CLK);
      Reset_n = 1'b1;
      run_op(2'b01, 32'd6, 32'd7, lat);
      chk("postreset_latency", 64'(lat), 64'(exp_lat(2'b01, 32'd7)));
      chk("postreset_r1", {32'd0, Result1}, 64'd42);
      chk("postreset_r2", {32'd0, Result2}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
